// File: rtl/lfsr_engine_if.sv
// Handshake/control bundle for the LFSR pattern engine.
// The master drives control and ready; the slave (engine) drives the stream and status.
interface lfsr_engine_if #(
  parameter int WIDTH = 16
) ();
  logic             load;
  logic [WIDTH-1:0] seed;
  logic             start;
  logic             stop;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] period;
  logic             period_done;
  logic             seed_err;

  modport master (
    output load, seed, start, stop, out_ready,
    input  out_valid, out_data, period, period_done, seed_err
  );

  modport slave (
    input  load, seed, start, stop, out_ready,
    output out_valid, out_data, period, period_done, seed_err
  );
endinterface

// File: rtl/lfsr_engine.sv
// Maximal-length LFSR pattern engine (Fibonacci or Galois form) with seed load,
// run control, valid/ready output stream and period measurement against the loaded seed.
module lfsr_engine #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
  parameter bit               GALOIS       = 1'b0,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 1
) (
  input  logic          clk,
  input  logic          nReset,
  lfsr_engine_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] seed_eff;
  logic             seed_zero;
  logic             step;

  generate
    if (GALOIS) begin : g_galois
      localparam logic [WIDTH-1:0] GMASK = {TAPS[WIDTH-2:0], 1'b1};
      assign lfsr_next = {lfsr_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{lfsr_q[WIDTH-1]}} & GMASK);
    end else begin : g_fibonacci
      assign lfsr_next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    end
  endgenerate

  // A load wins over a step in the same cycle, so the word after a load is always the seed.
  assign step      = (fsm_q == RUN) & bus.out_ready & ~bus.load;
  assign seed_zero = (bus.seed == '0);
  assign seed_eff  = seed_zero ? DEFAULT_SEED : bus.seed;

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (bus.start && !bus.stop) fsm_d = RUN;
      RUN:     if (bus.stop) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    lfsr_d   = lfsr_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    done_d   = 1'b0;
    err_d    = err_q;
    if (bus.load) begin
      lfsr_d = seed_eff;
      ref_d  = seed_eff;
      cnt_d  = '0;
      err_d  = seed_zero;
    end else if (step) begin
      lfsr_d = lfsr_next;
      if (lfsr_next == ref_q) begin
        // Saturating so a runaway count never reports a bogus small period.
        period_d = (cnt_q == ALL_ONES) ? ALL_ONES : cnt_q + WIDTH'(1);
        cnt_d    = '0;
        done_d   = 1'b1;
      end else if (cnt_q != ALL_ONES) begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      fsm_q    <= IDLE;
      lfsr_q   <= DEFAULT_SEED;
      ref_q    <= DEFAULT_SEED;
      cnt_q    <= '0;
      period_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      lfsr_q   <= lfsr_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.out_valid   = (fsm_q == RUN);
  assign bus.out_data    = lfsr_q;
  assign bus.period      = period_q;
  assign bus.period_done = done_q;
  assign bus.seed_err    = err_q;

endmodule

// File: tb/tb_lfsr_engine.sv
// Self-checking bench for lfsr_engine: Fibonacci and Galois instances, directed steps
// plus a randomized ready/load stream compared against a polynomial-arithmetic model.
module tb_lfsr_engine;

  localparam int          W     = 16;
  localparam logic [15:0] TAPS  = 16'hB400;
  localparam int          GPOLY = 32'h10000 | ((TAPS << 1) & 32'hFFFF) | 1;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  lfsr_engine_if #(.WIDTH(W)) if_f ();
  lfsr_engine_if #(.WIDTH(W)) if_g ();

  lfsr_engine #(.WIDTH(W), .TAPS(TAPS), .GALOIS(1'b0), .DEFAULT_SEED(16'h0001)) u_fib (
    .clk    (clk),
    .nReset (nReset),
    .bus    (if_f.slave)
  );

  lfsr_engine #(.WIDTH(W), .TAPS(TAPS), .GALOIS(1'b1), .DEFAULT_SEED(16'h0001)) u_gal (
    .clk    (clk),
    .nReset (nReset),
    .bus    (if_g.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_st;
  logic        m_run;
  int          m_steps;
  logic [15:0] g_st;

  // Fibonacci: shift left, new LSB = parity of tapped bits.
  function automatic logic [15:0] fib_next(input logic [15:0] s);
    int v;
    v = (int'(s) << 1) & 32'hFFFF;
    v = v | ($countones(s & TAPS) & 1);
    return 16'(v);
  endfunction

  // Galois: multiply by x modulo the feedback polynomial.
  function automatic logic [15:0] gal_next(input logic [15:0] s);
    int v;
    v = int'(s) << 1;
    if ((v & 32'h10000) != 0) v = v ^ GPOLY;
    return 16'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
      $display("check %s obs=%h", tag, obs);
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Advance the Fibonacci model from the inputs about to be sampled, then clock.
  task automatic tick();
    if (if_f.load) begin
      m_st = (if_f.seed == 16'h0) ? 16'h0001 : if_f.seed;
    end else if (m_run && if_f.out_ready) begin
      m_st = fib_next(m_st);
      m_steps++;
    end
    if (if_f.stop) m_run = 1'b0;
    else if (if_f.start) m_run = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gtick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    if_f.load = 0; if_f.seed = 0; if_f.start = 0; if_f.stop = 0; if_f.out_ready = 0;
    if_g.load = 0; if_g.seed = 0; if_g.start = 0; if_g.stop = 0; if_g.out_ready = 0;
    m_st = 16'h0001; m_run = 1'b0; m_steps = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(if_f.out_valid), 0);
    chk("rst_data", 32'(if_f.out_data), 32'h0001);
    chk("rst_period", 32'(if_f.period), 0);
    chk("rst_done", 32'(if_f.period_done), 0);
    chk("rst_err", 32'(if_f.seed_err), 0);
    @(negedge clk);
    nReset = 1'b1;
    @(posedge clk);
    #1;

    // T1: Fibonacci walk from 0x0001
    if_f.seed = 16'h0001; if_f.load = 1; tick(); if_f.load = 0;
    if_f.start = 1; tick(); if_f.start = 0;
    chk("t1_valid", 32'(if_f.out_valid), 1);
    chk("t1_first", 32'(if_f.out_data), 32'h0001);
    if_f.out_ready = 1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk($sformatf("t1_step%0d", k), 32'(if_f.out_data), 32'(m_st));
    end
    chk("t1_step11_lit", 32'(if_f.out_data), 32'h0801);

    // T2: Galois instance
    g_st = 16'h8000;
    if_g.seed = 16'h8000; if_g.load = 1; gtick(); if_g.load = 0;
    if_g.start = 1; gtick(); if_g.start = 0;
    chk("t2_seed", 32'(if_g.out_data), 32'h8000);
    if_g.out_ready = 1;
    gtick(); g_st = gal_next(g_st);
    chk("t2_step1", 32'(if_g.out_data), 32'(g_st));
    chk("t2_step1_lit", 32'(if_g.out_data), 32'h6801);
    gtick(); g_st = gal_next(g_st);
    if_g.out_ready = 0;
    chk("t2_step2", 32'(if_g.out_data), 32'(g_st));
    chk("t2_step2_lit", 32'(if_g.out_data), 32'hD002);

    // T5: zero seed protection, then recovery
    if_f.out_ready = 0; if_f.stop = 1; tick(); if_f.stop = 0;
    chk("t5_idle", 32'(if_f.out_valid), 0);
    if_f.seed = 16'h0000; if_f.load = 1; tick(); if_f.load = 0;
    chk("t5_err_set", 32'(if_f.seed_err), 1);
    chk("t5_subst", 32'(if_f.out_data), 32'h0001);
    if_f.seed = 16'h1234; if_f.load = 1; tick(); if_f.load = 0;
    chk("t5_err_clr", 32'(if_f.seed_err), 0);
    chk("t5_data", 32'(if_f.out_data), 32'h1234);

    // T4: random ready with occasional loads against the model
    if_f.start = 1; tick(); if_f.start = 0;
    for (int i = 0; i < 300; i++) begin
      if_f.out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) begin
        if_f.load = 1;
        if_f.seed = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      end
      tick();
      if_f.load = 0;
      chk($sformatf("t4_data%0d", i), 32'(if_f.out_data), 32'(m_st));
      chk($sformatf("t4_valid%0d", i), 32'(if_f.out_valid), 32'(m_run));
    end

    // T6: load + stop while running
    if_f.seed = 16'hBEEF; if_f.load = 1; if_f.stop = 1; tick();
    if_f.load = 0; if_f.stop = 0;
    chk("t6_valid", 32'(if_f.out_valid), 0);
    chk("t6_data", 32'(if_f.out_data), 32'hBEEF);
    tick();
    chk("t6_hold", 32'(if_f.out_data), 32'hBEEF);

    // T3: full period from 0xACE1
    if_f.seed = 16'hACE1; if_f.load = 1; tick(); if_f.load = 0;
    if_f.start = 1; if_f.out_ready = 1; tick(); if_f.start = 0;
    m_steps = 0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 70000 && !seen; i++) begin
        tick();
        if (if_f.period_done) seen = 1'b1;
      end
      chk("t3_done_seen", 32'(seen), 1);
    end
    chk("t3_steps", 32'(m_steps), 65535);
    chk("t3_period", 32'(if_f.period), 32'hFFFF);
    chk("t3_data", 32'(if_f.out_data), 32'hACE1);
    tick();
    chk("t3_done_pulse", 32'(if_f.period_done), 0);
    chk("t3_data_next", 32'(if_f.out_data), 32'(m_st));

    // Asynchronous reset while running
    nReset = 1'b0;
    #2;
    chk("arst_valid", 32'(if_f.out_valid), 0);
    chk("arst_data", 32'(if_f.out_data), 32'h0001);
    chk("arst_period", 32'(if_f.period), 0);
    @(negedge clk);
    nReset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
